delay_ms_arbiter: RTL and testbench
===================================

Name: delay_ms_arbiter

Overview:
- Shares one millisecond delay timer among N_REQ requester FSMs.
- Each requester asks for a delay of req_ms milliseconds and waits for a one-cycle done pulse.
- The block drives the timer's enable and ms inputs, watches its done output, and grants requesters in round-robin order.
- Sits between the top-level sequencing FSMs and the single delay timer instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MS_W, 32, width of a millisecond count; matches the timer's ms input.
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req  input  N_REQ  per-requester request level.
- req_ms  input  N_REQ*MS_W  per-requester delay value; slice i is bits [i*MS_W +: MS_W].
- done  output  N_REQ  one-cycle completion pulse per requester.
- busy  output  1  high while a grant is active (states RUN and GAP).
- grant_id  output  ID_W  index of the current or last granted requester.
- timer_enable  output  1  enable input of the shared timer.
- timer_ms  output  MS_W  ms input of the shared timer.
- timer_done  input  1  done level from the shared timer; held high while enable is high after expiry.

Behaviour:
- Everything is registered on the rising edge of clk. Reset is synchronous and active-high, and has priority over all other logic.
- Reset values: done=0, busy=0, grant_id=0, timer_enable=0, timer_ms=0, state=IDLE, rr_ptr=0.

State IDLE:
- If any req bit is high, select a winner g: the first set req bit scanning from rr_ptr upward, with wrap-around.
- On the next edge: grant_id<=g and timer_ms<=req_ms[g].
- If req_ms[g]!=0: timer_enable<=1, state<=RUN.
- If req_ms[g]==0: no timer use; done[g]<=1, state<=GAP.
- Latency: req seen at edge t gives timer_enable=1 after edge t+1.

State RUN:
- timer_ms is held constant.
- When timer_done==1 and req[g]==1: timer_enable<=0, done[g]<=1, state<=GAP.
- When req[g]==0 (requester withdrew, abort): timer_enable<=0, no done pulse, state<=GAP.
- If withdrawal and timer_done happen in the same cycle, the abort wins: no done pulse.
- Changes to req_ms[g] during RUN are ignored.

State GAP:
- done<=0, timer_enable stays 0. This guarantees at least one cycle with enable low so the timer restarts from zero.
- rr_ptr<=(g+1) mod N_REQ, state<=IDLE.

Handshake and timing:
- A requester holds req high and req_ms stable until it sees done, and may drop req in the cycle after done.
- A requester still high in IDLE after its own grant is treated as a new request, but is lowest priority because rr_ptr has advanced.
- At most one done bit is high in any cycle. done is never asserted in IDLE or RUN.
- Back-to-back grants: minimum spacing from one timer_enable rise to the next is the delay plus 3 cycles (RUN exit, GAP, IDLE).
- Reset mid-RUN: timer_enable drops on the reset edge and no done pulse is issued. Requesters must re-request after reset.
- Width rule: timer_ms is a straight copy of the MS_W slice, with no arithmetic.

Optional Feature:
Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority. IDLE always selects the lowest-index set req bit; rr_ptr is not implemented (grant_id logic only).
- Not defined: round-robin as described in Behaviour.
- All other states and timing are identical in both modes.

Test Plan:
- Single request: req=4'b0001, req_ms[0]=10 → timer_enable rises 1 cycle later with timer_ms=10; the timer model asserts done after 10 ms; done[0] pulses exactly 1 cycle; busy high throughout; grant_id=0.
- Round-robin: req=4'b1111 held for 4 grants, all req_ms=2 → grant order 0,1,2,3 and each done bit pulses once. With ARB_FIXED_PRIO_EN and req held, requester 0 is re-granted every time.
- Zero delay: req=4'b0100, req_ms[2]=0 → timer_enable never rises; done[2] pulses 1 cycle after request; grant_id=2.
- Abort: req[1] high with req_ms=50; drop req[1] mid-RUN → timer_enable falls next edge; no done pulse; then req[3] is granted after the GAP cycle.
- Reset mid-operation: rst=1 for 1 cycle during RUN → next cycle all outputs 0, state IDLE; a fresh req=4'b0010 is granted normally with grant_id=1.
- Restart gap: two consecutive grants → timer_enable is low for at least 2 cycles between them, and timer_ms switches to the new value before enable rises.

Source files
------------

// File: rtl/delay_ms_arbiter_if.sv
// Bundle between the requester FSMs, the delay arbiter and the shared ms timer.
// slave  : arbiter view (takes requests and timer_done, drives done/grant/timer controls)
// master : environment view (requesters and timer model)
// Signals: req, req_ms (slice i = [i*MS_W +: MS_W]), done, busy, grant_id,
//          timer_enable, timer_ms, timer_done.
interface delay_ms_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned MS_W  = 32,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ*MS_W-1:0] req_ms;
    logic [N_REQ-1:0]      done;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;
    logic                  timer_enable;
    logic [MS_W-1:0]       timer_ms;
    logic                  timer_done;

    modport slave (
        input  req, req_ms, timer_done,
        output done, busy, grant_id, timer_enable, timer_ms
    );

    modport master (
        output req, req_ms, timer_done,
        input  done, busy, grant_id, timer_enable, timer_ms
    );
endinterface

// File: rtl/delay_ms_arbiter.sv
// Shares one millisecond delay timer among N_REQ requesters.
// A winner is picked in IDLE, its delay is loaded into the timer (RUN), and a
// one-cycle done pulse is returned when the timer expires. A GAP cycle always
// follows a grant so the timer sees enable low and restarts from zero.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - delay_ms_arbiter_if.slave (requests, done pulses, timer controls)
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index priority;
// default is round-robin starting after the last granted requester.
module delay_ms_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned MS_W  = 32,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    delay_ms_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic                en_q, en_d;
    logic [MS_W-1:0]     ms_q, ms_d;

    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic [MS_W-1:0]     win_ms;
    logic                cur_req;

`ifndef ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [2*N_REQ-1:0]  req_rot;
    int unsigned         idx;
`endif

    // Winner selection: lowest index (fixed) or first set bit from rr_q (round-robin)
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(k);
            end
        end
`else
        // req_rot[k] holds req[(rr_q + k) mod N_REQ]
        req_rot = {bus.req, bus.req} >> rr_q;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                idx = 32'(rr_q) + 32'(k);
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
`endif
    end

    // Delay value of the selected requester
    always_comb begin
        win_ms = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (ID_W'(j) == win_id) begin
                win_ms = bus.req_ms[j*MS_W +: MS_W];
            end
        end
    end

    // Request level of the currently granted requester
    assign cur_req = |(bus.req & (N_REQ'(1) << gid_q));

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= '0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            en_q    <= 1'b0;
            ms_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            en_q    <= en_d;
            ms_q    <= ms_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Next-state logic; withdrawal and expiry both leave RUN through GAP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = (win_ms != '0) ? RUN : GAP;
                end
            end
            RUN: begin
                if (!cur_req || bus.timer_done) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next output values; abort has priority over timer expiry in RUN
    always_comb begin
        done_d = '0;
        en_d   = en_q;
        gid_d  = gid_q;
        ms_d   = ms_q;
        busy_d = (state_d != IDLE);
`ifndef ARB_FIXED_PRIO_EN
        rr_d   = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gid_d = win_id;
                    ms_d  = win_ms;
                    if (win_ms != '0) begin
                        en_d = 1'b1;
                    end else begin
                        done_d = N_REQ'(1) << win_id;
                    end
                end
            end
            RUN: begin
                if (!cur_req) begin
                    en_d = 1'b0;
                end else if (bus.timer_done) begin
                    en_d   = 1'b0;
                    done_d = N_REQ'(1) << gid_q;
                end
            end
            GAP: begin
                en_d = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                rr_d = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + ID_W'(1);
`endif
            end
            default: en_d = 1'b0;
        endcase
    end

    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = gid_q;
    assign bus.timer_enable = en_q;
    assign bus.timer_ms     = ms_q;

endmodule

// File: tb/tb_delay_ms_arbiter.sv
// Self-checking bench for delay_ms_arbiter: directed scenarios followed by
// randomized request sets, checked against a transaction-level model
// (winner choice from a pointer, done latency from the timer's period).
module tb_delay_ms_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned MS_W  = 32;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CPM   = 3;   // timer model cycles per millisecond

    logic clk;
    logic rst;
    logic [31:0] cnt;

    int checks;
    int errors;
    int rr;          // model's round-robin start point

    delay_ms_arbiter_if #(.N_REQ(N_REQ), .MS_W(MS_W), .ID_W(ID_W)) bus ();

    delay_ms_arbiter #(.N_REQ(N_REQ), .MS_W(MS_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared timer model: counts while enabled, done level once ms*CPM cycles elapsed
    always_ff @(posedge clk) begin
        if (!bus.timer_enable) cnt <= '0;
        else                   cnt <= cnt + 32'd1;
    end
    assign bus.timer_done = bus.timer_enable && (cnt >= bus.timer_ms * CPM);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            if (r[k]) return k;
`else
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
`endif
        end
        return -1;
    endfunction

    task automatic check_out(input string tag, input logic [N_REQ-1:0] e_done,
                             input logic e_en, input logic e_busy,
                             input logic [ID_W-1:0] e_gid, input logic [MS_W-1:0] e_ms);
        logic [63:0] obs;
        logic [63:0] exp;
        obs = 64'({bus.done, bus.timer_enable, bus.busy, bus.grant_id, bus.timer_ms});
        exp = 64'({e_done, e_en, e_busy, e_gid, e_ms});
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed done=%b en=%b busy=%b gid=%0d ms=%0d, expected done=%b en=%b busy=%b gid=%0d ms=%0d",
                   tag, bus.done, bus.timer_enable, bus.busy, bus.grant_id, bus.timer_ms,
                   e_done, e_en, e_busy, e_gid, e_ms);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ms(input int i, input int v);
        bus.req_ms[i*MS_W +: MS_W] = MS_W'(v);
    endtask

    // One complete grant; caller has req set and the arbiter idle
    task automatic serve(input bit abort, input bit drop, input bit perturb);
        int w;
        int n;
        int lat;
        bit seen;
        logic [MS_W-1:0] ms;
        logic [N_REQ-1:0] oh;
        w = pick(bus.req, rr);
        if (w < 0) begin
            check_int("pick_valid", w, 0);
            return;
        end
        ms = bus.req_ms[w*MS_W +: MS_W];
        oh = N_REQ'(1) << w;
`ifndef ARB_FIXED_PRIO_EN
        rr = (w + 1) % N_REQ;
`endif
        @(posedge clk); #1;
        if (ms == '0) begin
            check_out("zero_grant", oh, 1'b0, 1'b1, ID_W'(w), ms);
            @(negedge clk);
            if (drop) bus.req[w] = 1'b0;
            @(posedge clk); #1;
            check_out("zero_idle", '0, 1'b0, 1'b0, ID_W'(w), ms);
            return;
        end
        check_out("grant", '0, 1'b1, 1'b1, ID_W'(w), ms);
        if (abort) begin
            @(negedge clk);
            bus.req[w] = 1'b0;
            @(posedge clk); #1;
            check_out("abort_gap", '0, 1'b0, 1'b1, ID_W'(w), ms);
            @(posedge clk); #1;
            check_out("abort_idle", '0, 1'b0, 1'b0, ID_W'(w), ms);
            return;
        end
        if (perturb) begin
            @(negedge clk);
            set_ms(w, int'($urandom_range(1, 9)));
        end
        lat  = int'(ms) * CPM + 1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < lat + 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.done !== '0) seen = 1'b1;
            else check_out("run", '0, 1'b1, 1'b1, ID_W'(w), ms);
        end
        check_out("done_pulse", oh, 1'b0, 1'b1, ID_W'(w), ms);
        check_int("done_latency", n, lat);
        @(negedge clk);
        if (drop) bus.req[w] = 1'b0;
        @(posedge clk); #1;
        check_out("post_done", '0, 1'b0, 1'b0, ID_W'(w), ms);
    endtask

    initial begin
        int w;
        int guard;
        logic [N_REQ-1:0] mask;
        checks = 0;
        errors = 0;
        rr     = 0;
        rst    = 1'b1;
        bus.req    = '0;
        bus.req_ms = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all requests held
        for (int i = 0; i < N_REQ; i++) set_ms(i, 2);
        bus.req = '1;
        for (int i = 0; i < 4; i++) serve(1'b0, 1'b0, 1'b0);
        bus.req = '0;

        // Single request
        @(negedge clk);
        set_ms(0, 10);
        bus.req = 4'b0001;
        serve(1'b0, 1'b1, 1'b0);

        // Zero delay
        set_ms(2, 0);
        bus.req = 4'b0100;
        serve(1'b0, 1'b1, 1'b0);

        // Reset in the middle of RUN
        set_ms(1, 5);
        bus.req = 4'b0010;
        w = pick(bus.req, rr);
        @(posedge clk); #1;
        check_out("rst_grant", '0, 1'b1, 1'b1, ID_W'(w), 5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(posedge clk); #1;
        check_out("rst_mid_run", '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        rr  = 0;

        // Abort of requester 1, then requester 3 served
        set_ms(1, 50);
        set_ms(3, 3);
        bus.req = 4'b1010;
        serve(1'b1, 1'b1, 1'b0);
        serve(1'b0, 1'b1, 1'b0);

        // Fresh request after reset and abort
        set_ms(1, 2);
        bus.req = 4'b0010;
        serve(1'b0, 1'b1, 1'b0);

        // Randomized request sets
        for (int it = 0; it < 12; it++) begin
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) set_ms(i, int'($urandom_range(0, 4)));
            bus.req = mask;
            guard = 0;
            while (bus.req != '0 && guard < 16) begin
                serve($urandom_range(0, 3) == 0, 1'b1, $urandom_range(0, 1) == 1);
                guard++;
            end
            check_int("rand_drained", int'(bus.req), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
